// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART transmitter.
// Holds the FSM state encoding, parity modes and frame arithmetic.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP
   } state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Parity bit for the low nbits of word; odd mode inverts the XOR.
   function automatic logic parity_bit(input logic [8:0] word, input int nbits, input int mode);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 9; i++)
         if (i < nbits) p = p ^ word[i];
      return (mode == PARITY_ODD) ? ~p : p;
   endfunction

   // Cycles from the first start bit to the last stop bit of a frame.
   function automatic int frame_len(input int nb, input int db, input int par,
                                    input int sb, input int gap);
      return nb * (1 + db + ((par != PARITY_NONE) ? 1 : 0) + sb) + (nb - 1) * gap;
   endfunction

endpackage

// File: rtl/uart_tx_word_ser.sv
// Single-word serialiser: loads a word, shifts it out LSB first on request
// and flags once every data bit has been handed out.
module uart_tx_word_ser
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0
)
(
   input  logic                 clk_9k6hz,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [DATA_BITS-1:0] word_i,
   input  logic                 shift_i,
   output logic                 bit_o,
   output logic                 par_o,
   output logic                 done_o
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);

   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 par_q, par_d;

   // cnt counts bits already handed to the line, so done means the last one is out.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      if (load_i) begin
         shreg_d = word_i;
         cnt_d   = '0;
         par_d   = parity_bit(9'(word_i), DATA_BITS, PARITY);
      end else if (shift_i) begin
         shreg_d = shreg_q >> 1;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_9k6hz or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   assign bit_o  = shreg_q[0];
   assign par_o  = par_q;
   assign done_o = (cnt_q == CNT_W'(DATA_BITS));

endmodule

// File: rtl/uart_tx_frame.sv
// Framed UART transmitter: sequences NUM_BYTES words through the word
// serialiser with parity, stop bits, inter-word gap, abort and handshake.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int NUM_BYTES  = 2,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int GAP_CYCLES = 4
)
(
   input  logic                                           clk_9k6hz,
   input  logic                                           rst_n,
   input  logic                                           start,
   input  logic [DATA_BITS*NUM_BYTES-1:0]                 data,
   input  logic                                           abort,
   output logic                                           tx,
   output logic                                           busy,
   output logic                                           byte_done,
   output logic [((NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1)-1:0] byte_idx,
   output logic                                           frame_done
);

   localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam bit HAS_PAR = (PARITY == PARITY_EVEN) || (PARITY == PARITY_ODD);

   state_e                         state_q, state_d;
   logic [IDX_W-1:0]               word_q, word_d, word_nx;
   logic [DATA_BITS*NUM_BYTES-1:0] data_q, data_d;
   logic                           stop_q, stop_d;
   logic [3:0]                     gap_q, gap_d;
   logic                           tx_q, tx_d, busy_q, busy_d;
   logic                           bd_q, bd_d, fd_q, fd_d, pend_q, pend_d;
   logic [IDX_W-1:0]               idx_q, idx_d;

   logic                 ser_load, ser_shift, ser_bit, ser_par, ser_done;
   logic [DATA_BITS-1:0] ser_word;

   assign word_nx = word_q + 1'b1;

   uart_tx_word_ser #(
      .DATA_BITS (DATA_BITS),
      .PARITY    (PARITY)
   ) u_ser (
      .clk_9k6hz (clk_9k6hz),
      .rst_n     (rst_n),
      .load_i    (ser_load),
      .word_i    (ser_word),
      .shift_i   (ser_shift),
      .bit_o     (ser_bit),
      .par_o     (ser_par),
      .done_o    (ser_done)
   );

   // tx_d is the line level for the state being entered, so tx is a plain register.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      data_d    = data_q;
      stop_d    = stop_q;
      gap_d     = gap_q;
      tx_d      = 1'b1;
      busy_d    = busy_q;
      bd_d      = 1'b0;
      idx_d     = idx_q;
      fd_d      = 1'b0;
      pend_d    = 1'b0;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
      ser_word  = data_q[DATA_BITS-1:0];

      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            // A start seen in the frame_done cycle launches one cycle late,
            // keeping back-to-back frames two idle bits apart.
            if (pend_q || (start && !fd_q)) begin
               if (!pend_q) begin
                  data_d   = data;
                  ser_word = data[DATA_BITS-1:0];
               end
               ser_load = 1'b1;
               word_d   = '0;
               busy_d   = 1'b1;
               tx_d     = 1'b0;
               state_d  = S_START;
            end else if (start) begin
               data_d = data;
               pend_d = 1'b1;
            end
         end
         S_START: begin
            tx_d      = ser_bit;
            ser_shift = 1'b1;
            state_d   = S_DATA;
         end
         S_DATA: begin
            if (!ser_done) begin
               tx_d      = ser_bit;
               ser_shift = 1'b1;
            end else if (HAS_PAR) begin
               tx_d    = ser_par;
               state_d = S_PARITY;
            end else begin
               stop_d  = 1'b0;
               state_d = S_STOP;
            end
         end
         S_PARITY: begin
            stop_d  = 1'b0;
            state_d = S_STOP;
         end
         S_STOP: begin
            if (stop_q == 1'(STOP_BITS - 1)) begin
               bd_d  = 1'b1;
               idx_d = word_q;
               if (word_q == IDX_W'(NUM_BYTES - 1)) begin
                  fd_d    = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else if (GAP_CYCLES > 0) begin
                  gap_d   = '0;
                  state_d = S_GAP;
               end else begin
                  word_d   = word_nx;
                  ser_load = 1'b1;
                  ser_word = data_q[word_nx*DATA_BITS +: DATA_BITS];
                  tx_d     = 1'b0;
                  state_d  = S_START;
               end
            end else begin
               stop_d = stop_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == 4'(GAP_CYCLES - 1)) begin
               word_d   = word_nx;
               ser_load = 1'b1;
               ser_word = data_q[word_nx*DATA_BITS +: DATA_BITS];
               tx_d     = 1'b0;
               state_d  = S_START;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything, including a coinciding final stop edge.
      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         tx_d      = 1'b1;
         busy_d    = 1'b0;
         bd_d      = 1'b0;
         fd_d      = 1'b0;
         idx_d     = idx_q;
         ser_load  = 1'b0;
         ser_shift = 1'b0;
      end
   end

   always_ff @(posedge clk_9k6hz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         data_q  <= '0;
         stop_q  <= 1'b0;
         gap_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         bd_q    <= 1'b0;
         idx_q   <= '0;
         fd_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         data_q  <= data_d;
         stop_q  <= stop_d;
         gap_q   <= gap_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         bd_q    <= bd_d;
         idx_q   <= idx_d;
         fd_q    <= fd_d;
         pend_q  <= pend_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign byte_done  = bd_q;
   assign byte_idx   = idx_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four parameterisations, one monitored
// at a time; a model pushes the expected per-cycle line/pulse trace.
module tb_uart_tx_frame;
   import uart_pkg::*;

   typedef struct packed {
      logic       tx;
      logic       busy;
      logic       bd;
      logic       fd;
      logic [2:0] idx;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, abort_a, no_abort;
   logic        st_a, st_b, st_c, st_d;
   logic [15:0] d_a, d_d;
   logic [7:0]  d_b, d_c;
   logic        tx_a, busy_a, bd_a, fd_a, tx_b, busy_b, bd_b, fd_b;
   logic        tx_c, busy_c, bd_c, fd_c, tx_d, busy_d, bd_d, fd_d;
   logic [0:0]  idx_a, idx_b, idx_c, idx_d;

   int   sel;
   exp_t q[$];
   int   errs = 0;
   int   nchk = 0;
   int   busy_cnt = 0;

   uart_tx_frame #(.DATA_BITS(8), .NUM_BYTES(2), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(4)) u_a (
      .clk_9k6hz(clk), .rst_n(rst_n), .start(st_a), .data(d_a), .abort(abort_a),
      .tx(tx_a), .busy(busy_a), .byte_done(bd_a), .byte_idx(idx_a), .frame_done(fd_a));
   uart_tx_frame #(.DATA_BITS(8), .NUM_BYTES(1), .PARITY(1), .STOP_BITS(1), .GAP_CYCLES(4)) u_b (
      .clk_9k6hz(clk), .rst_n(rst_n), .start(st_b), .data(d_b), .abort(no_abort),
      .tx(tx_b), .busy(busy_b), .byte_done(bd_b), .byte_idx(idx_b), .frame_done(fd_b));
   uart_tx_frame #(.DATA_BITS(8), .NUM_BYTES(1), .PARITY(2), .STOP_BITS(1), .GAP_CYCLES(4)) u_c (
      .clk_9k6hz(clk), .rst_n(rst_n), .start(st_c), .data(d_c), .abort(no_abort),
      .tx(tx_c), .busy(busy_c), .byte_done(bd_c), .byte_idx(idx_c), .frame_done(fd_c));
   uart_tx_frame #(.DATA_BITS(8), .NUM_BYTES(2), .PARITY(0), .STOP_BITS(2), .GAP_CYCLES(0)) u_d (
      .clk_9k6hz(clk), .rst_n(rst_n), .start(st_d), .data(d_d), .abort(no_abort),
      .tx(tx_d), .busy(busy_d), .byte_done(bd_d), .byte_idx(idx_d), .frame_done(fd_d));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic t, input logic b, input logic bd,
                               input logic fd, input logic [2:0] idx);
      exp_t e;
      e.tx = t; e.busy = b; e.bd = bd; e.fd = fd; e.idx = idx;
      return e;
   endfunction

   // Expected trace, one entry per cycle starting the cycle after acceptance.
   task automatic push_frame(input int nb, input int db, input int par, input int sb,
                             input int gap, input logic [71:0] d);
      logic       p, b, pbd;
      logic [2:0] pidx;
      pbd = 1'b0;
      pidx = '0;
      for (int k = 0; k < nb; k++) begin
         q.push_back(mk(1'b0, 1'b1, pbd, 1'b0, pidx));
         pbd = 1'b0;
         p = 1'b0;
         for (int i = 0; i < db; i++) begin
            b = d[k*db + i];
            p = p ^ b;
            q.push_back(mk(b, 1'b1, 1'b0, 1'b0, 3'd0));
         end
         if (par != 0) q.push_back(mk((par == 2) ? ~p : p, 1'b1, 1'b0, 1'b0, 3'd0));
         for (int s = 0; s < sb; s++) q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
         pbd = 1'b1;
         pidx = 3'(k);
         if (k < nb - 1)
            for (int g = 0; g < gap; g++) begin
               q.push_back(mk(1'b1, 1'b1, pbd, 1'b0, pidx));
               pbd = 1'b0;
            end
      end
      q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'(nb - 1)));
   endtask

   always @(negedge clk) begin : mon
      exp_t       e;
      logic [3:0] o;
      logic [2:0] oi;
      case (sel)
         0:       begin o = {tx_a, busy_a, bd_a, fd_a}; oi = 3'(idx_a); end
         1:       begin o = {tx_b, busy_b, bd_b, fd_b}; oi = 3'(idx_b); end
         2:       begin o = {tx_c, busy_c, bd_c, fd_c}; oi = 3'(idx_c); end
         default: begin o = {tx_d, busy_d, bd_d, fd_d}; oi = 3'(idx_d); end
      endcase
      if (q.size() > 0) e = q.pop_front();
      else              e = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      chk("tx",         32'(o[3]), 32'(e.tx));
      chk("busy",       32'(o[2]), 32'(e.busy));
      chk("byte_done",  32'(o[1]), 32'(e.bd));
      chk("frame_done", 32'(o[0]), 32'(e.fd));
      if (e.bd) chk("byte_idx", 32'(oi), 32'(e.idx));
      if (o[2]) busy_cnt++;
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic fire(input int s, input logic [15:0] dv);
      sel = s;
      case (s)
         0:       begin d_a = dv;      st_a = 1'b1; push_frame(2, 8, 0, 1, 4, 72'(dv)); end
         1:       begin d_b = dv[7:0]; st_b = 1'b1; push_frame(1, 8, 1, 1, 4, 72'(dv[7:0])); end
         2:       begin d_c = dv[7:0]; st_c = 1'b1; push_frame(1, 8, 2, 1, 4, 72'(dv[7:0])); end
         default: begin d_d = dv;      st_d = 1'b1; push_frame(2, 8, 0, 2, 0, 72'(dv)); end
      endcase
      wait_neg(1);
      st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; st_d = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk(tag, 32'(q.size()), 32'd0);
      wait_neg(3);
   endtask

   initial begin : stim
      int b0;
      rst_n = 1'b0; abort_a = 1'b0; no_abort = 1'b0; sel = 0;
      st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; st_d = 1'b0;
      d_a = '0; d_b = '0; d_c = '0; d_d = '0;
      wait_neg(3);
      chk("rst_tx", 32'(tx_a), 32'd1);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_idx", 32'(idx_a), 32'd0);
      rst_n = 1'b1;
      wait_neg(2);

      b0 = busy_cnt;
      fire(0, 16'hA53C);
      drain("drain_default");
      chk("busy_len_default", 32'(busy_cnt - b0), 32'(frame_len(2, 8, 0, 1, 4)));

      fire(1, 16'h003C); drain("drain_even_3c");
      fire(1, 16'h0007); drain("drain_even_07");
      fire(2, 16'h003C); drain("drain_odd_3c");

      b0 = busy_cnt;
      fire(3, 16'hFF00);
      drain("drain_stop2");
      chk("busy_len_stop2", 32'(busy_cnt - b0), 32'(frame_len(2, 8, 0, 2, 0)));

      // Abort during bit 3 of word 1 (cycle 18), then restart straight away.
      fire(0, 16'h5A81);
      wait_neg(18);
      abort_a = 1'b1;
      q.delete();
      wait_neg(1);
      abort_a = 1'b0;
      fire(0, 16'h0F0F);
      drain("drain_after_abort");

      abort_a = 1'b1;
      wait_neg(2);
      abort_a = 1'b0;
      wait_neg(2);

      // start held high: two frames separated by the frame_done and launch cycles.
      sel = 0;
      d_a = 16'hC3E1;
      st_a = 1'b1;
      push_frame(2, 8, 0, 1, 4, 72'(16'hC3E1));
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
      push_frame(2, 8, 0, 1, 4, 72'(16'h1EE7));
      wait_neg(6);
      d_a = 16'h1EE7;
      wait_neg(25);
      st_a = 1'b0;
      drain("drain_held_start");

      // Asynchronous reset in the middle of the data bits.
      fire(0, 16'h6699);
      wait_neg(3);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("arst_tx", 32'(tx_a), 32'd1);
      chk("arst_busy", 32'(busy_a), 32'd0);
      wait_neg(2);
      rst_n = 1'b1;
      wait_neg(2);
      fire(0, 16'h3CA5);
      drain("drain_after_reset");

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised successor to the two-byte UART serialiser: sends a frame of NUM_BYTES words, each DATA_BITS wide.
- Per-word framing: optional parity, 1 or 2 stop bits, configurable idle gap between words.
- Runs one bit per clk_9k6hz cycle with a start/busy handshake, abort, and per-word/per-frame completion pulses.
- Sits between the command formatter and the TX pin.

Parameters:
- DATA_BITS, 8: bits per word, 5..9.
- NUM_BYTES, 2: words per frame, 1..8.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: stop bits per word, 1 or 2.
- GAP_CYCLES, 4: idle-high cycles between words, 0..15. No gap after the last word.

Ports:
- clk_9k6hz  in  1  bit clock; one UART bit per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- data  in  DATA_BITS*NUM_BYTES  frame payload; word k = data[k*DATA_BITS +: DATA_BITS].
- abort  in  1  cancel the frame in progress.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- byte_done  out  1  one-cycle pulse per completed word.
- byte_idx  out  max(1,clog2(NUM_BYTES))  index of the word that just completed; valid with byte_done.
- frame_done  out  1  one-cycle pulse when the whole frame completes.

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, busy=0, byte_done=0, frame_done=0, byte_idx=0, state=IDLE.
  - Counters and shift register cleared.
  - Reset mid-frame drops the frame immediately; tx returns high asynchronously.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE:
  - tx=1, busy=0.
  - start=1 at an edge: latch data, word=0, busy=1, enter START.
  - The tx=0 start bit appears in the cycle after that edge.
  - start is ignored while busy.
- START: one cycle, tx=0 → DATA.
- DATA:
  - DATA_BITS cycles, word LSB first, words in order 0..NUM_BYTES-1.
  - → PARITY if PARITY!=0, else → STOP.
- PARITY: one cycle.
  - Even: tx = XOR of the word.
  - Odd: tx = inverted XOR of the word.
- STOP: STOP_BITS cycles, tx=1.
  - At the edge ending the last stop cycle: byte_done=1 and byte_idx=word for the following cycle.
  - If word==NUM_BYTES-1: frame_done=1 in that same cycle, busy→0, → IDLE.
  - Else if GAP_CYCLES>0: → GAP.
  - Else: word+1, → START.
- GAP: GAP_CYCLES cycles, tx=1, then word+1, → START.
- Timing:
  - Frame length from the first start-bit cycle to the last stop-bit cycle: NUM_BYTES*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) + (NUM_BYTES-1)*GAP_CYCLES.
  - Earliest restart: start sampled in the cycle busy=0 (the frame_done cycle). The next start bit follows one cycle later, so there are at least 2 idle-high cycles between frames.
- Abort:
  - abort=1 while busy: at that edge tx=1, busy=0, → IDLE.
  - No byte_done or frame_done for the partial word.
  - Words already completed keep the pulses they already produced.
  - abort in IDLE has no effect.
  - If abort and the final stop edge coincide, abort wins: no frame_done.
- data changes while busy have no effect; the frame is latched at acceptance.

Decomposition:
- Shared package uart_pkg holds:
  - state enum;
  - PARITY_NONE/EVEN/ODD constants;
  - parity function;
  - frame-length function used by the bench.
- One sub-module, uart_tx_word_ser: serialises one word (shift register, bit counter, parity accumulator) on a load pulse and reports done.
- The top handles word sequencing, the gap counter, abort and handshake.

Test Plan:
- Defaults, data=16'hA53C, start for one cycle → tx sequence: 0 00111100 1, 1111, 0 10100101 1. busy high for 24 cycles. byte_done at word ends with byte_idx 0 then 1. frame_done with the second byte_done.
- PARITY=1, NUM_BYTES=1, data=8'h3C → 0 00111100 0 1. Same stimulus with PARITY=2 → parity bit 1. data=8'h07, PARITY=1 → parity bit 1.
- STOP_BITS=2, GAP_CYCLES=0, data=16'hFF00 → word0 followed by 2 stop bits, then an immediate start bit for word1. Total 22 cycles.
- abort asserted during bit 3 of word 1 → tx=1 the next cycle, busy=0. Exactly one byte_done (idx 0), no frame_done. A new start is accepted the next cycle.
- start held high continuously → frames repeat with exactly 2 idle cycles between the last stop bit and the next start bit. start pulses while busy have no effect.
- rst_n pulsed low mid-DATA → tx=1 and busy=0 immediately, asynchronously. No pulses. A normal frame follows after reset release.
